// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int DEF_D        = 5;
    localparam int DEF_W        = 32;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic {
        PORT_WB0 = 1'b0,
        PORT_WB1 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [DEF_D-1:0] addr;
        logic [DEF_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Pending-destination tracker for long-latency (port 1) writes; feeds hazard stalls.
module regfile_scoreboard #(
    parameter int D = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         claim_valid,
    input  logic [D-1:0] claim_addr,
    input  logic         clear_valid,
    input  logic [D-1:0] clear_addr,
    input  logic [D-1:0] query_addr1,
    input  logic [D-1:0] query_addr2,
    output logic         busy1,
    output logic         busy2
);

    localparam int N = 1 << D;

    logic [N-1:0] pending;

    // The set is written last so a same-cycle claim beats a retiring write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clear_valid) pending[clear_addr] <= 1'b0;
            if (claim_valid) pending[claim_addr] <= 1'b1;
        end
    end

    assign busy1 = pending[query_addr1];
    assign busy2 = pending[query_addr2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port arbiter for the register-file write port: writeback has priority, an
// anti-starvation counter forces port 1 through. REGFILE_ARB_SCOREBOARD_EN adds pending tracking.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int D        = DEF_D,
    parameter int W        = DEF_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb0_valid,
    input  logic [D-1:0] wb0_addr,
    input  logic [W-1:0] wb0_data,
    output logic         wb0_ready,
    input  logic         wb1_valid,
    input  logic [D-1:0] wb1_addr,
    input  logic [W-1:0] wb1_data,
    output logic         wb1_ready,
    input  logic         claim_valid,
    input  logic [D-1:0] claim_addr,
    input  logic [D-1:0] query_addr1,
    input  logic [D-1:0] query_addr2,
    output logic         busy1,
    output logic         busy2,
    output logic [D-1:0] rf_address3,
    output logic [W-1:0] rf_write_data,
    output logic         rf_write_enable
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;
    logic          force_grant;
    logic          acc0;
    logic          acc1;
    logic          en_q;
    port_id_e      win_port;

    // Handshake: a transfer happens on a posedge where valid && ready; the requester
    // holds valid/addr/data until then. Each ready depends only on the other port's valid.
    assign force_grant = (wait_cnt == MAX_CNT);
    assign wb0_ready   = !rst && (!force_grant || !wb1_valid);
    assign wb1_ready   = !rst && (!wb0_valid || force_grant);
    assign acc0        = wb0_valid && wb0_ready;
    assign acc1        = wb1_valid && wb1_ready;
    assign win_port    = acc1 ? PORT_WB1 : PORT_WB0;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q          <= 1'b0;
            rf_address3   <= '0;
            rf_write_data <= '0;
            wait_cnt      <= '0;
        end else begin
            en_q <= acc0 || acc1;
            if (acc0 || acc1) begin
                rf_address3   <= (win_port == PORT_WB1) ? wb1_addr : wb0_addr;
                rf_write_data <= (win_port == PORT_WB1) ? wb1_data : wb0_data;
            end
            if (!wb1_valid || acc1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != MAX_CNT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // Reset also masks the in-flight write so the negedge commit cannot happen.
    assign rf_write_enable = en_q && !rst;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic sb_busy1;
    logic sb_busy2;

    regfile_scoreboard #(.D(D)) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .clear_valid (acc1),
        .clear_addr  (wb1_addr),
        .query_addr1 (query_addr1),
        .query_addr2 (query_addr2),
        .busy1       (sb_busy1),
        .busy2       (sb_busy2)
    );

    assign busy1 = sb_busy1 && !rst;
    assign busy2 = sb_busy2 && !rst;
`else
    logic unused_claim;

    assign unused_claim = ^{claim_valid, claim_addr, query_addr1, query_addr2};
    assign busy1        = 1'b0;
    assign busy2        = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: fixed vector table, corner sequences, random traffic vs a model.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int D    = DEF_D;
    localparam int W    = DEF_W;
    localparam int MW   = DEF_MAX_WAIT;
    localparam int NREG = 1 << D;
`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         wb0_valid, wb1_valid, claim_valid;
    logic [D-1:0] wb0_addr, wb1_addr, claim_addr, query_addr1, query_addr2;
    logic [W-1:0] wb0_data, wb1_data;
    logic         wb0_ready, wb1_ready, busy1, busy2;
    logic [D-1:0] rf_address3;
    logic [W-1:0] rf_write_data;
    logic         rf_write_enable;

    regfile_write_arbiter #(.D(D), .W(W), .MAX_WAIT(MW)) dut (
        .clk             (clk),
        .rst             (rst),
        .wb0_valid       (wb0_valid),
        .wb0_addr        (wb0_addr),
        .wb0_data        (wb0_data),
        .wb0_ready       (wb0_ready),
        .wb1_valid       (wb1_valid),
        .wb1_addr        (wb1_addr),
        .wb1_data        (wb1_data),
        .wb1_ready       (wb1_ready),
        .claim_valid     (claim_valid),
        .claim_addr      (claim_addr),
        .query_addr1     (query_addr1),
        .query_addr2     (query_addr2),
        .busy1           (busy1),
        .busy2           (busy2),
        .rf_address3     (rf_address3),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: how long port 1 has waited, the last accepted write, pending claims.
    int           m_waited;
    bit           m_en;
    logic [D-1:0] m_addr;
    logic [W-1:0] m_data;
    bit           m_pend [NREG];
    bit           m_acc0, m_acc1;

    logic         s_r0, s_r1, s_en, s_b1, s_b2;
    logic [D-1:0] s_addr;
    logic [W-1:0] s_data;

    int n_vec;
    int n_bad;

    typedef struct {
        bit           v0;
        wr_req_t      q0;
        bit           v1;
        wr_req_t      q1;
        bit           r0;
        bit           r1;
        bit           en;
        wr_req_t      out;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v0, logic [D-1:0] a0, logic [W-1:0] d0,
                                bit v1, logic [D-1:0] a1, logic [W-1:0] d1,
                                bit r0, bit r1, bit en, logic [D-1:0] ea, logic [W-1:0] ed);
        vec_t v;
        v.v0  = v0; v.q0  = '{addr: a0, data: d0};
        v.v1  = v1; v.q1  = '{addr: a1, data: d1};
        v.r0  = r0; v.r1  = r1; v.en = en;
        v.out = '{addr: ea, data: ed};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_waited = 0;
        m_en     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    endtask

    task automatic drive0(input bit v, input logic [D-1:0] a, input logic [W-1:0] d);
        wb0_valid = v; wb0_addr = a; wb0_data = d;
    endtask

    task automatic drive1(input bit v, input logic [D-1:0] a, input logic [W-1:0] d);
        wb1_valid = v; wb1_addr = a; wb1_data = d;
    endtask

    task automatic claim(input bit v, input logic [D-1:0] a);
        claim_valid = v; claim_addr = a;
    endtask

    task automatic query(input logic [D-1:0] q1, input logic [D-1:0] q2);
        query_addr1 = q1; query_addr2 = q2;
    endtask

    // One clock: compare at negedge against the model, then advance the model at posedge.
    task automatic step();
        bit overdue, e_r0, e_r1;
        @(negedge clk);
        overdue = (m_waited >= MW);
        e_r0 = !rst && !(overdue && wb1_valid);
        e_r1 = !rst && (!wb0_valid || overdue);
        s_r0 = wb0_ready; s_r1 = wb1_ready; s_en = rf_write_enable;
        s_addr = rf_address3; s_data = rf_write_data; s_b1 = busy1; s_b2 = busy2;
        check("wb0_ready", 64'(s_r0), 64'(e_r0));
        check("wb1_ready", 64'(s_r1), 64'(e_r1));
        check("rf_write_enable", 64'(s_en), 64'(m_en && !rst));
        check("rf_address3", 64'(s_addr), 64'(m_addr));
        check("rf_write_data", 64'(s_data), 64'(m_data));
        check("busy1", 64'(s_b1), 64'(SB_ON && !rst && m_pend[query_addr1]));
        check("busy2", 64'(s_b2), 64'(SB_ON && !rst && m_pend[query_addr2]));
        m_acc0 = wb0_valid && e_r0;
        m_acc1 = wb1_valid && e_r1;
        @(posedge clk);
        if (rst) begin
            model_reset();
            m_acc0 = 1'b0;
            m_acc1 = 1'b0;
        end else begin
            m_en = m_acc0 || m_acc1;
            if (m_acc0) begin
                m_addr = wb0_addr; m_data = wb0_data;
            end else if (m_acc1) begin
                m_addr = wb1_addr; m_data = wb1_data;
            end
            if (!wb1_valid || m_acc1) m_waited = 0;
            else if (m_waited < MW) m_waited++;
            if (m_acc1) m_pend[wb1_addr] = 1'b0;
            if (claim_valid) m_pend[claim_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        drive0(0, '0, '0); drive1(0, '0, '0); claim(0, '0); query('0, '0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;

        // Solo requests, then both valid for two 4:1 starvation rounds.
        tbl.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 3, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            1, 7, 5,     1, 1, 0, 3, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 7, 32'h5));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 0, 7, 32'h5));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 2, 32'h22));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11));
        tbl.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 1, 32'h11));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 2, 32'h22));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 2, 32'h22));

        for (int i = 0; i < tbl.size(); i++) begin
            drive0(tbl[i].v0, tbl[i].q0.addr, tbl[i].q0.data);
            drive1(tbl[i].v1, tbl[i].q1.addr, tbl[i].q1.data);
            step();
            check("tbl_wb0_ready", 64'(s_r0), 64'(tbl[i].r0));
            check("tbl_wb1_ready", 64'(s_r1), 64'(tbl[i].r1));
            check("tbl_rf_write_enable", 64'(s_en), 64'(tbl[i].en));
            check("tbl_rf_address3", 64'(s_addr), 64'(tbl[i].out.addr));
            check("tbl_rf_write_data", 64'(s_data), 64'(tbl[i].out.data));
        end

        // Idle: enable low, address and data hold.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_en", 64'(s_en), 64'(0));
            check("idle_addr", 64'(s_addr), 64'(2));
            check("idle_data", 64'(s_data), 64'h22);
        end

        // Reset in the cycle after an acceptance, with port 1 part-way to a forced grant.
        drive0(1, 10, 32'hAA); drive1(1, 12, 32'hBB);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_en_dropped", 64'(s_en), 64'(0));
        check("rst_wb0_ready", 64'(s_r0), 64'(0));
        check("rst_wb1_ready", 64'(s_r1), 64'(0));
        check("rst_busy", 64'({s_b1, s_b2}), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < MW; i++) begin
            step();
            check("post_rst_wait", 64'(s_r1), 64'(0));
        end
        step();
        check("post_rst_force1", 64'(s_r1), 64'(1));
        check("post_rst_force0", 64'(s_r0), 64'(0));
        drive0(0, 0, 0); drive1(0, 0, 0);
        step();

        // Pending tracking: claim, retire, same-cycle claim+retire, second query port.
        query(9, 4);
        claim(1, 9); step(); claim(0, 0);
        step();
        check("claim_busy1", 64'(s_b1), 64'(SB_ON));
        drive1(1, 9, 32'h99); step(); drive1(0, 0, 0);
        check("retire_cycle_busy1", 64'(s_b1), 64'(SB_ON));
        step();
        check("retired_busy1", 64'(s_b1), 64'(0));
        claim(1, 9); step(); claim(0, 0);
        claim(1, 9); drive1(1, 9, 32'h98); step(); claim(0, 0); drive1(0, 0, 0);
        step();
        check("set_wins_busy1", 64'(s_b1), 64'(SB_ON));
        claim(1, 4); step(); claim(0, 0);
        step();
        check("claim4_busy2", 64'(s_b2), 64'(SB_ON));
        query(4, 9);
        step();
        check("claim4_busy1", 64'(s_b1), 64'(SB_ON));
        check("still9_busy2", 64'(s_b2), 64'(SB_ON));

        // Random traffic; requesters hold their request until it is accepted.
        drive0(0, 0, 0); drive1(0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!wb0_valid && $urandom_range(0, 2) != 0)
                drive0(1, D'($urandom_range(0, NREG - 1)), $urandom());
            if (!wb1_valid && $urandom_range(0, 1) != 0)
                drive1(1, D'($urandom_range(0, 7)), $urandom());
            claim($urandom_range(0, 3) == 0, D'($urandom_range(0, 7)));
            query(D'($urandom_range(0, 7)), D'($urandom_range(0, 7)));
            step();
            if (m_acc0) wb0_valid = 1'b0;
            if (m_acc1) wb1_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
